// File: rtl/cal_eep_master.sv
// SPI master for the calibration EEPROM: each read or write is a 16-bit command
// frame followed by a 16-bit response frame that returns the data or the write acknowledge.
module cal_eep_master #(
  parameter int          SCLK_HALF = 16,
  parameter int          GAP       = 16,
  parameter logic [15:0] ACK       = 16'hA5A5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rd_req,
  input  logic       wr_req,
  input  logic [5:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       done,
  output logic       busy,
  output logic       ack_err,
  output logic       SS_n,
  output logic       SCLK,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_GAP, S_RSP, S_FIN} state_t;

  localparam int PW = $clog2(2 * SCLK_HALF + 1);
  localparam int GW = $clog2(GAP + 1);
  localparam logic [PW-1:0] PH_LAST    = PW'(2 * SCLK_HALF - 1);
  localparam logic [PW-1:0] PH_RISE    = PW'(SCLK_HALF);
  localparam logic [PW-1:0] PH_BP_LAST = PW'(SCLK_HALF - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP - 1);

  state_t        state_q;
  logic [PW-1:0] phase_q;
  logic [4:0]    bit_q;
  logic [GW-1:0] gap_q;
  logic [15:0]   tx_q;
  logic [15:0]   rx_q;
  logic          is_wr_q;
  logic [7:0]    rdata_q;
  logic          done_q, busy_q, ack_err_q, ss_n_q, sclk_q, mosi_q;

  logic [PW-1:0] phase_d;
  logic [4:0]    bit_d;
  logic          bit_adv, frame_end, sclk_rise;
  logic [15:0]   cmd_word;

  // Position within the frame one cycle ahead; outputs are registered from it.
  always_comb begin
    bit_adv   = (phase_q == PH_LAST);
    frame_end = (bit_q == 5'd16) && (phase_q == PH_BP_LAST);
    if (bit_adv) begin
      phase_d = '0;
      bit_d   = bit_q + 5'd1;
    end else begin
      phase_d = phase_q + PW'(1);
      bit_d   = bit_q;
    end
    sclk_rise = (bit_d < 5'd16) && (phase_d == PH_RISE);
    // A simultaneous read and write request resolves to the read.
    cmd_word  = rd_req ? {2'b00, addr, 8'h00} : {2'b01, addr, wdata};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      phase_q   <= '0;
      bit_q     <= '0;
      gap_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      is_wr_q   <= 1'b0;
      rdata_q   <= 8'h00;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      ack_err_q <= 1'b0;
      ss_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rd_req || wr_req) begin
            state_q <= S_CMD;
            is_wr_q <= !rd_req;
            tx_q    <= cmd_word;
            mosi_q  <= cmd_word[15];
            ss_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            phase_q <= '0;
            bit_q   <= '0;
          end
        end
        S_CMD, S_RSP: begin
          if (frame_end) begin
            ss_n_q <= 1'b1;
            sclk_q <= 1'b0;
            gap_q  <= '0;
            if (state_q == S_CMD) begin
              state_q <= S_GAP;
            end else begin
              state_q <= S_FIN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              if (is_wr_q) begin
                ack_err_q <= (rx_q != ACK);
              end else begin
                rdata_q   <= rx_q[7:0];
                ack_err_q <= (rx_q[15:8] != 8'h00);
              end
            end
          end else begin
            phase_q <= phase_d;
            bit_q   <= bit_d;
            sclk_q  <= (bit_d < 5'd16) && (phase_d >= PH_RISE);
            if (sclk_rise) begin
              rx_q <= {rx_q[14:0], MISO};
            end
            // MOSI changes only at bit boundaries and holds through the back porch.
            if (bit_adv && (bit_d < 5'd16)) begin
              tx_q   <= {tx_q[14:0], 1'b0};
              mosi_q <= tx_q[14];
            end
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            state_q <= S_RSP;
            tx_q    <= 16'hC000;
            mosi_q  <= 1'b1;
            ss_n_q  <= 1'b0;
            phase_q <= '0;
            bit_q   <= '0;
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end
        S_FIN: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rdata   = rdata_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign ack_err = ack_err_q;
  assign SS_n    = ss_n_q;
  assign SCLK    = sclk_q;
  assign MOSI    = mosi_q;

endmodule

// File: tb/tb_cal_eep_master.sv
// Bench for cal_eep_master: an EEPROM slave model answers the frames, and a reference
// memory plus frame-timing arithmetic provide the expected results.
module tb_cal_eep_master;

  localparam int SH       = 16;
  localparam int GP       = 16;
  localparam int FR       = 32 * SH + SH;
  localparam int DONE_CYC = 2 * FR + GP + 1;
  localparam int BOUND    = 3000;

  logic       clk = 1'b0;
  logic       rst_n, rd_req, wr_req, MISO;
  logic [5:0] addr;
  logic [7:0] wdata, rdata;
  logic       done, busy, ack_err, SS_n, SCLK, MOSI;

  int n_checks = 0;
  int n_errors = 0;

  cal_eep_master #(.SCLK_HALF(SH), .GAP(GP), .ACK(16'hA5A5)) dut (
    .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .wr_req(wr_req), .addr(addr),
    .wdata(wdata), .rdata(rdata), .done(done), .busy(busy), .ack_err(ack_err),
    .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO)
  );

  always #5 clk = ~clk;

  // EEPROM slave model, CPOL=0/CPHA=0: shifts out on SCLK fall, captures on SCLK rise.
  logic [7:0]  smem [64];
  logic [15:0] s_in, s_out;
  logic [15:0] s_rsp = 16'h0000;
  int          s_nbits = 0;
  logic        s_prev_ss = 1'b1, s_prev_sclk = 1'b0;
  bit          nack_mode = 1'b0;
  logic [15:0] mosi_log[$];

  always @(negedge clk) begin
    if (!SS_n && s_prev_ss) begin
      s_out = s_rsp; MISO = s_rsp[15]; s_nbits = 0; s_in = 16'h0;
    end else if (!SS_n) begin
      if (SCLK && !s_prev_sclk) begin
        s_in = {s_in[14:0], MOSI}; s_nbits++;
      end else if (!SCLK && s_prev_sclk) begin
        s_out = {s_out[14:0], 1'b0}; MISO = s_out[15];
      end
    end else if (!s_prev_ss && s_nbits == 16) begin
      mosi_log.push_back(s_in);
      if (s_in[15:14] == 2'b00) begin
        s_rsp = {(nack_mode ? 8'hFF : 8'h00), smem[s_in[13:8]]};
      end else if (s_in[15:14] == 2'b01) begin
        smem[s_in[13:8]] = s_in[7:0];
        s_rsp = nack_mode ? 16'h0000 : 16'hA5A5;
      end
    end
    s_prev_ss = SS_n; s_prev_sclk = SCLK;
  end

  logic [7:0] ref_mem [64];
  logic [7:0] exp_rdata = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic run_op(input bit do_rd, input bit do_wr, input logic [5:0] a,
                        input logic [7:0] d, input bit nack, input bit late_wr,
                        input string tag);
    int ss_runs[$];
    int run = 0, gap = 0, first_low = -1, done_cyc = -1, done_cnt = 0, busy_cnt = 0;
    int rises = 0, bad_rise = 0, hi_run = 0, hi_min = 1000000, hi_max = 0;
    logic prev_ss = 1'b1, prev_sclk = 1'b0;
    logic [7:0] rd_at_done = 8'hxx;
    logic ack_at_done = 1'bx, busy_at_done = 1'bx;
    logic [15:0] exp_cmd;
    logic exp_ack;
    if (do_rd) begin
      exp_cmd = {2'b00, a, 8'h00};
      exp_rdata = ref_mem[a];
    end else begin
      exp_cmd = {2'b01, a, d};
      ref_mem[a] = d;
    end
    exp_ack = nack;
    nack_mode = nack;
    mosi_log.delete();
    @(negedge clk);
    rd_req = do_rd; wr_req = do_wr; addr = a; wdata = d;
    @(negedge clk);
    rd_req = 1'b0; wr_req = 1'b0; addr = 6'($urandom); wdata = 8'($urandom);
    for (int cyc = 1; cyc <= BOUND; cyc++) begin
      if (late_wr) wr_req = (cyc == 300);
      if (!SS_n) begin
        if (first_low < 0) first_low = cyc;
        run++;
      end else begin
        if (!prev_ss) begin ss_runs.push_back(run); run = 0; end
        if (first_low >= 0 && ss_runs.size() == 1) gap++;
      end
      if (SCLK && !prev_sclk) begin
        rises++;
        if (SS_n) bad_rise++;
      end
      if (SCLK) hi_run++;
      else if (prev_sclk) begin
        if (hi_run < hi_min) hi_min = hi_run;
        if (hi_run > hi_max) hi_max = hi_run;
        hi_run = 0;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc; rd_at_done = rdata; ack_at_done = ack_err; busy_at_done = busy;
        end
      end
      prev_ss = SS_n; prev_sclk = SCLK;
      if (done_cyc > 0 && cyc >= done_cyc + 20) break;
      @(negedge clk);
    end
    wr_req = 1'b0;
    check({tag, " done_cycle"}, done_cyc, DONE_CYC);
    check({tag, " done_pulses"}, done_cnt, 1);
    check({tag, " ss_first_low"}, first_low, 1);
    check({tag, " ss_frames"}, ss_runs.size(), 2);
    check({tag, " ss_len_f1"}, (ss_runs.size() > 0) ? ss_runs[0] : -1, FR);
    check({tag, " ss_len_f2"}, (ss_runs.size() > 1) ? ss_runs[1] : -1, FR);
    check({tag, " ss_gap"}, gap, GP);
    check({tag, " sclk_rises"}, rises, 32);
    check({tag, " sclk_rise_ss_high"}, bad_rise, 0);
    check({tag, " sclk_hi_min"}, hi_min, SH);
    check({tag, " sclk_hi_max"}, hi_max, SH);
    check({tag, " busy_cycles"}, busy_cnt, DONE_CYC - 1);
    check({tag, " busy_at_done"}, busy_at_done, 0);
    check({tag, " mosi_frames"}, mosi_log.size(), 2);
    check({tag, " mosi_cmd"}, (mosi_log.size() > 0) ? mosi_log[0] : 16'hxxxx, exp_cmd);
    check({tag, " mosi_rsp"}, (mosi_log.size() > 1) ? mosi_log[1] : 16'hxxxx, 16'hC000);
    check({tag, " rdata"}, rd_at_done, exp_rdata);
    check({tag, " ack_err"}, ack_at_done, exp_ack);
    check({tag, " rdata_hold"}, rdata, exp_rdata);
    $display("op %s rd=%0b wr=%0b addr=%0h wdata=%0h rdata=%0h ack_err=%0b done@%0d",
             tag, do_rd, do_wr, a, d, rd_at_done, ack_at_done, done_cyc);
  endtask

  initial begin
    logic [7:0] v;
    int done_seen;
    rst_n = 1'b0; rd_req = 1'b0; wr_req = 1'b0; addr = '0; wdata = '0; MISO = 1'b0;
    for (int i = 0; i < 64; i++) begin
      v = 8'($urandom);
      smem[i] = v; ref_mem[i] = v;
    end
    smem[5] = 8'h3C; ref_mem[5] = 8'h3C;
    repeat (3) @(negedge clk);
    check("reset SS_n", SS_n, 1); check("reset SCLK", SCLK, 0); check("reset MOSI", MOSI, 0);
    check("reset busy", busy, 0); check("reset done", done, 0);
    check("reset ack_err", ack_err, 0); check("reset rdata", rdata, 8'h00);
    rst_n = 1'b1;

    run_op(1, 0, 6'h05, 8'h00, 0, 0, "read5");
    run_op(0, 1, 6'h12, 8'h9A, 0, 0, "write12");
    run_op(1, 0, 6'h12, 8'h00, 0, 0, "read12");
    run_op(0, 1, 6'h21, 8'h77, 1, 0, "write_nack");
    run_op(1, 0, 6'h21, 8'h00, 1, 0, "read_badhdr");
    run_op(1, 1, 6'h05, 8'hEE, 0, 1, "collision");

    // Reset 200 cycles into a read aborts it with no done pulse.
    @(negedge clk);
    rd_req = 1'b1; addr = 6'h0A;
    @(negedge clk);
    rd_req = 1'b0;
    repeat (199) @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_rdata = 8'h00;
    check("rst SS_n", SS_n, 1); check("rst SCLK", SCLK, 0); check("rst busy", busy, 0);
    check("rst rdata", rdata, 8'h00);
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done || !SS_n) done_seen++;
    end
    check("rst no_done", done_seen, 0);
    $display("op reset_abort addr=0a rdata=%0h", rdata);
    run_op(1, 0, 6'h0A, 8'h00, 0, 0, "read_after_rst");

    for (int i = 0; i < 6; i++) begin
      logic [5:0] ra;
      ra = 6'($urandom);
      if ($urandom_range(1) == 1)
        run_op(0, 1, ra, 8'($urandom), 0, 0, "rand_write");
      else
        run_op(1, 0, ra, 8'h00, 0, 0, "rand_read");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cal_eep_master.md
CAL_EEP_MASTER -- requirements
Module: cal_eep_master

Interface
REQ-001 Parameter SCLK_HALF, default 16, clk cycles per SCLK half-period.
REQ-002 Parameter GAP, default 16, minimum clk cycles SS_n is high between the two frames of one operation.
REQ-003 Parameter ACK, default 16'hA5A5, expected write-acknowledge word.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 rd_req  input  1  one-cycle pulse to request an EEPROM read.
REQ-007 wr_req  input  1  one-cycle pulse to request an EEPROM write.
REQ-008 addr  input  6  EEPROM address, captured at request.
REQ-009 wdata  input  8  write data, captured at request.
REQ-010 rdata  output  8  read result, valid from done onward.
REQ-011 done  output  1  one-cycle pulse at operation completion.
REQ-012 busy  output  1  high while an operation is in progress.
REQ-013 ack_err  output  1  high when the response word failed its check; valid with done.
REQ-014 SS_n  output  1  active-low slave select.
REQ-015 SCLK  output  1  serial clock, idles low (CPOL=0, CPHA=0).
REQ-016 MOSI  output  1  serial data to EEPROM, MSB first.
REQ-017 MISO  input  1  serial data from EEPROM, MSB first.

Function
REQ-018 Each operation is two 16-bit frames: command frame, then response frame.
REQ-019 Command word: read = {2'b00, addr, 8'h00}; write = {2'b01, addr, wdata}.
REQ-020 Response frame MOSI word = 16'hC000 (opcode 11, ignored by the EEPROM).
REQ-021 Frame timing: SS_n low for 16*2*SCLK_HALF + SCLK_HALF clk (528 at defaults).
REQ-022 Bit period k (k=0..15) = 2*SCLK_HALF clk: SCLK low for first SCLK_HALF, high for second; MOSI = word[15-k] for the whole period.
REQ-023 After bit 15, a back porch of SCLK_HALF clk with SCLK low, MOSI held, then SS_n rises.
REQ-024 MISO sampled into a 16-bit shift register on the clk edge where SCLK goes 0->1; 16 samples per frame.
REQ-025 SS_n held high exactly GAP clk between command frame and response frame.
REQ-026 States: IDLE, CMD, GAP, RSP, FIN; IDLE->CMD on accepted request; CMD->GAP at end of frame; GAP->RSP after GAP cycles; RSP->FIN at end of frame; FIN->IDLE unconditionally.
REQ-027 Latency (defaults): request sampled at cycle 0; SS_n low cycles 1-528; high 529-544; low 545-1072; done high cycle 1073.
REQ-028 busy high cycles 1-1072; low in IDLE and in FIN.
REQ-029 Read completion: rdata = rx[7:0]; ack_err = (rx[15:8] != 8'h00).
REQ-030 Write completion: rdata unchanged; ack_err = (rx != ACK).
REQ-031 rdata and ack_err update only in FIN and hold until the next FIN.
REQ-032 rd_req and wr_req both high in IDLE: read accepted, write dropped.
REQ-033 Requests while busy or in FIN are ignored, not queued.
REQ-034 addr and wdata are captured at acceptance; later changes do not affect the operation.
REQ-035 SCLK makes exactly 16 rising edges per frame; none while SS_n high.

Reset
REQ-036 rst_n low asynchronously forces: state IDLE, SS_n=1, SCLK=0, MOSI=0, busy=0, done=0, ack_err=0, rdata=8'h00, all counters 0.
REQ-037 Reset mid-frame aborts immediately, with no done pulse; the first request after release starts a fresh command frame.

Verification
REQ-038 Read, addr=6'h05, EEPROM mem[5]=8'h3C -> MOSI frame 1 = 16'h0500, frame 2 = 16'hC000; rdata=8'h3C, ack_err=0, done at cycle 1073.
REQ-039 Write, addr=6'h12, wdata=8'h9A -> MOSI frame 1 = 16'h529A; MISO frame 2 = 16'hA5A5; ack_err=0; a subsequent read of 6'h12 returns 8'h9A.
REQ-040 Write with slave model forcing frame-2 MISO = 16'h0000 -> ack_err=1 with done; rdata unchanged.
REQ-041 rd_req and wr_req same cycle, then wr_req pulse at cycle 300 -> only one read operation, one done pulse, and 16 SCLK rising edges per frame.
REQ-042 rst_n asserted at cycle 200 of a read -> SS_n=1 and SCLK=0 in the same cycle, no done; a read issued after release completes correctly.
REQ-043 Timing check at defaults -> SCLK high/low phases of 16 clk, SS_n low 528 clk per frame, 16 clk gap between frames.
